// File: rtl/iob_fifo_async_pkg.sv
// Shared sizing helpers for the single-clock FIFO and its storage array.
package iob_fifo_async_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int LVL_W      = DEF_ADDR_W + 1;

  function automatic int fifo_depth(input int aw);
    return 2 ** aw;
  endfunction

  // Level needs one more bit than the address to represent a full FIFO.
  function automatic int fifo_lvl_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/iob_fifo_mem.sv
// FIFO storage: one write port, one registered read port whose output resets to 0.
module iob_fifo_mem
  import iob_fifo_async_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_data <= '0;
    else if (r_en) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/iob_fifo_async.sv
// Single-clock FIFO exposing the dual-clock FIFO's write/read port set.
module iob_fifo_async
  import iob_fifo_async_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          w_en,
  input  logic [DATA_W-1:0]             w_data,
  output logic                          w_full,
  output logic [fifo_lvl_w(ADDR_W)-1:0] w_level,
  input  logic                          r_en,
  output logic [DATA_W-1:0]             r_data,
  output logic                          r_empty,
  output logic [fifo_lvl_w(ADDR_W)-1:0] r_level
);

  localparam logic [ADDR_W:0] PTR_INC = 1;

  logic [ADDR_W:0] wptr, rptr, level;
  logic            w_go, r_go;

  // Wrap bit disambiguates full from empty when the addresses match.
  assign level   = wptr - rptr;
  assign r_empty = (wptr == rptr);
  assign w_full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign w_level = level;
  assign r_level = level;

  assign w_go = w_en && !w_full;
  assign r_go = r_en && !r_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (w_go) wptr <= wptr + PTR_INC;
      if (r_go) rptr <= rptr + PTR_INC;
    end
  end

  iob_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (w_go),
    .w_addr (wptr[ADDR_W-1:0]),
    .w_data (w_data),
    .r_en   (r_go),
    .r_addr (rptr[ADDR_W-1:0]),
    .r_data (r_data)
  );

endmodule

// File: tb/tb_iob_fifo_async.sv
// Bench for iob_fifo_async: queue-based reference model, vector table and directed corner sequences.
module tb_iob_fifo_async;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       w_en = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       w_full;
  logic [4:0] w_level;
  logic       r_en = 1'b0;
  logic [7:0] r_data;
  logic       r_empty;
  logic [4:0] r_level;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] rd_m = 8'h00;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       full;
    logic       empty;
    logic [4:0] lvl;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl[34];

  iob_fifo_async #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w_en    (w_en),
    .w_data  (w_data),
    .w_full  (w_full),
    .w_level (w_level),
    .r_en    (r_en),
    .r_data  (r_data),
    .r_empty (r_empty),
    .r_level (r_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_full"},   {31'd0, w_full},  {31'd0, q.size() == 16});
    chk({tag, "_empty"},  {31'd0, r_empty}, {31'd0, q.size() == 0});
    chk({tag, "_wlevel"}, {27'd0, w_level}, q.size());
    chk({tag, "_rlevel"}, {27'd0, r_level}, q.size());
    chk({tag, "_rdata"},  {24'd0, r_data},  {24'd0, rd_m});
  endtask

  // One clock: drive, let the model act on the pre-edge occupancy, then compare.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input string tag, output logic rok);
    logic wok;
    w_en = w; w_data = d; r_en = r;
    @(posedge clk);
    wok = w && (q.size() < 16);
    rok = r && (q.size() > 0);
    if (rok) rd_m = q.pop_front();
    if (wok) q.push_back(d);
    #1;
    chk_model(tag);
  endtask

  task automatic model_reset();
    q.delete();
    rd_m = 8'h00;
  endtask

  initial begin
    logic rok;
    int wb, rb, n, pause_cnt;
    bit paused;

    for (int i = 0; i < 34; i++) begin
      if (i < 16) tbl[i] = '{1'b1, 8'(i), 1'b0, i == 15, 1'b0, 5'(i + 1), 8'h00};
      else if (i == 16) tbl[i] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 5'd16, 8'h00};
      else if (i < 33) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, (i - 17) == 15, 5'(15 - (i - 17)), 8'(i - 17)};
      else tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 8'h0F};
    end

    // Reset asserted between edges must act without a clock.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, "empty_read", rok);

    for (int i = 0; i < 34; i++) begin
      cyc(tbl[i].w, tbl[i].d, tbl[i].r, "tbl_model", rok);
      chk("tbl_full",  {31'd0, w_full},  {31'd0, tbl[i].full});
      chk("tbl_empty", {31'd0, r_empty}, {31'd0, tbl[i].empty});
      chk("tbl_level", {27'd0, w_level}, {27'd0, tbl[i].lvl});
      chk("tbl_rdata", {24'd0, r_data},  {24'd0, tbl[i].rd});
    end

    // Simultaneous traffic at level 8.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, "sim_fill", rok);
    for (int j = 0; j < 10; j++) begin
      cyc(1'b1, 8'(8'h18 + j), 1'b1, "sim_both", rok);
      chk("sim_level", {27'd0, w_level}, 32'd8);
      chk("sim_data",  {24'd0, r_data},  32'(8'h10 + j));
    end
    for (int j = 0; j < 8; j++) begin
      cyc(1'b0, 8'h00, 1'b1, "sim_drain", rok);
      chk("sim_drain_data", {24'd0, r_data}, 32'(8'h1A + j));
    end

    // Streaming 256 bytes: pointers wrap many times, writer pauses mid-way.
    wb = 0; rb = 0; n = 0; pause_cnt = 0; paused = 0;
    while (rb < 256 && n < 4000) begin
      logic w, r;
      if (wb == 128 && !paused) begin paused = 1; pause_cnt = 60; end
      w = (n % 2 == 0) && wb < 256 && pause_cnt == 0 && q.size() < 16;
      r = (q.size() > 0) && ($urandom_range(0, 3) != 0);
      cyc(w, 8'(wb), r, "stream", rok);
      if (w) wb++;
      if (rok) begin
        chk("stream_data", {24'd0, r_data}, 32'(rb[7:0]));
        rb++;
      end
      if (pause_cnt > 0) pause_cnt--;
      n++;
    end
    chk("stream_count", rb, 32'd256);

    // Random mix against the model.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, "rand", rok);

    // Reset in the middle of operation.
    while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1, "pre_drain", rok);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, "mid_fill", rok);
    chk("mid_level5", {27'd0, w_level}, 32'd5);
    w_en = 1'b0; r_en = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_model("mid_reset");
    #1 rst_n = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0, "post_wr", rok);
    cyc(1'b0, 8'h00, 1'b1, "post_rd", rok);
    chk("post_rdata", {24'd0, r_data}, 32'h5A);
    chk("post_empty", {31'd0, r_empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
